// File: rtl/snn_pkg.sv
// Shared types, default parameters and arithmetic helpers for the LIF output layer.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRE  = 2'd2
  } state_t;

  localparam int unsigned DEF_IN_SIZE      = 16;
  localparam int unsigned DEF_IN_WIDTH     = 4;
  localparam int unsigned DEF_OUTPUT_SIZE  = 10;
  localparam int unsigned DEF_OUTPUT_WIDTH = 4;
  localparam int unsigned DEF_W_WIDTH      = 8;
  localparam int unsigned DEF_V_WIDTH      = 12;
  localparam int unsigned DEF_THRESHOLD    = 64;
  localparam int unsigned DEF_LEAK_SHIFT   = 3;

  // Signed add clamped to the range of a 'width'-bit two's complement value.
  // Operands are pre-extended to 32 bits, so the raw sum itself cannot wrap.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned       width);
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s  = a + b;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/lif_acc_neuron.sv
// One LIF neuron: saturating weight accumulation, leak, threshold and subtractive reset.
module lif_acc_neuron
  import snn_pkg::*;
#(
  parameter int unsigned W_WIDTH    = DEF_W_WIDTH,
  parameter int unsigned V_WIDTH    = DEF_V_WIDTH,
  parameter int unsigned THRESHOLD  = DEF_THRESHOLD,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic               i_clk,
  input  logic               i_add_en,
  input  logic [W_WIDTH-1:0] i_weight,
  input  logic               i_fire,
  input  logic               i_clear,
  output logic               o_fire
);

  localparam logic signed [V_WIDTH-1:0] TH = V_WIDTH'(THRESHOLD);

  logic signed [V_WIDTH-1:0] r_v;
  logic signed [V_WIDTH-1:0] w_leak;
  logic signed [V_WIDTH-1:0] w_vl;
  logic signed [V_WIDTH-1:0] w_sum;
  logic                      w_above;

  // Leaked potential, threshold test and saturated accumulation result.
  always_comb begin
    w_leak  = r_v >>> LEAK_SHIFT;
    w_vl    = r_v - w_leak;
    w_above = (w_vl >= TH);
    w_sum   = V_WIDTH'(sat_add(32'(r_v), 32'($signed(i_weight)), V_WIDTH));
  end

  assign o_fire = i_fire && w_above;

  // Membrane potential: clear wins over fire, fire wins over accumulate.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_v <= '0;
    end else if (i_fire) begin
      r_v <= w_above ? (w_vl - TH) : w_vl;
    end else if (i_add_en) begin
      r_v <= w_sum;
    end
  end

endmodule

// File: rtl/lif_out_layer.sv
// Time-multiplexed LIF output layer: row-serial weight accumulation, then leak/fire per timestep.
module lif_out_layer
  import snn_pkg::*;
#(
  parameter int unsigned IN_SIZE      = DEF_IN_SIZE,
  parameter int unsigned IN_WIDTH     = DEF_IN_WIDTH,
  parameter int unsigned OUTPUT_SIZE  = DEF_OUTPUT_SIZE,
  parameter int unsigned OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int unsigned W_WIDTH      = DEF_W_WIDTH,
  parameter int unsigned V_WIDTH      = DEF_V_WIDTH,
  parameter int unsigned THRESHOLD    = DEF_THRESHOLD,
  parameter int unsigned LEAK_SHIFT   = DEF_LEAK_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_SIZE-1:0]      in_spike,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    w_wr,
  input  logic [IN_WIDTH-1:0]     w_row,
  input  logic [OUTPUT_WIDTH-1:0] w_col,
  input  logic [W_WIDTH-1:0]      w_data,
  output logic [OUTPUT_SIZE-1:0]  spike_out,
  output logic                    frame_valid
);

  state_t                   r_state;
  logic [IN_WIDTH-1:0]      r_j;
  logic [IN_SIZE-1:0]       r_spk;
  logic                     r_last;
  logic [OUTPUT_SIZE-1:0]   r_spike_out;
  logic                     r_frame_valid;
  logic                     r_out_last;
  logic [W_WIDTH-1:0]       r_w [IN_SIZE][OUTPUT_SIZE];

  logic                     w_add_en;
  logic                     w_fire;
  logic                     w_clear;
  logic [OUTPUT_SIZE-1:0]   w_fired;

  assign in_ready    = (r_state == IDLE) && !rst;
  assign w_add_en    = (r_state == ACCUM) && r_spk[r_j];
  assign w_fire      = (r_state == FIRE);
  assign w_clear     = rst || (w_fire && r_last);
  assign spike_out   = r_spike_out;
  assign frame_valid = r_frame_valid;

  // Weight RAM, writable only while idle; unmatched (out-of-range) addresses fall through the decode.
  always_ff @(posedge clk) begin
    if (w_wr && (r_state == IDLE)) begin
      for (int unsigned r = 0; r < IN_SIZE; r++) begin
        for (int unsigned c = 0; c < OUTPUT_SIZE; c++) begin
          if ((w_row == IN_WIDTH'(r)) && (w_col == OUTPUT_WIDTH'(c))) begin
            r_w[r][c] <= w_data;
          end
        end
      end
    end
  end

  // Control FSM with the input latch, row counter and registered spike/frame outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_j           <= '0;
      r_spk         <= '0;
      r_last        <= 1'b0;
      r_spike_out   <= '0;
      r_frame_valid <= 1'b0;
      r_out_last    <= 1'b0;
    end else begin
      r_spike_out <= '0;
      r_out_last  <= 1'b0;
      if (r_out_last) begin
        r_frame_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_spk   <= in_spike;
            r_last  <= in_last;
            r_j     <= '0;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (r_j == IN_WIDTH'(IN_SIZE - 1)) begin
            r_state <= FIRE;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        FIRE: begin
          r_spike_out   <= w_fired;
          r_frame_valid <= 1'b1;
          r_out_last    <= r_last;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < OUTPUT_SIZE; k++) begin : g_neu
    lif_acc_neuron #(
      .W_WIDTH   (W_WIDTH),
      .V_WIDTH   (V_WIDTH),
      .THRESHOLD (THRESHOLD),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_neu (
      .i_clk   (clk),
      .i_add_en(w_add_en),
      .i_weight(r_w[r_j][k]),
      .i_fire  (w_fire),
      .i_clear (w_clear),
      .o_fire  (w_fired[k])
    );
  end

endmodule
